// File: rtl/brq_md_iter_ctrl.sv
// Iterative multiply/divide sequencer: 32-cycle shift-add multiply and restoring divide
// on a shared 33-bit adder, with sign correction and a valid/ack result handshake.
module brq_md_iter_ctrl #(
  parameter bit ZeroShortcut = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ack_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  localparam logic [1:0] OpMull = 2'd0;
  localparam logic [1:0] OpMulh = 2'd1;
  localparam logic [1:0] OpDiv  = 2'd2;
  localparam logic [1:0] OpRem  = 2'd3;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAbs  = 3'd1;
  localparam logic [2:0] StIter = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q;
  logic [1:0]  mode_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] mag_b_q;
  logic [31:0] result_q;

  logic        accept;
  logic        is_mul;
  logic        div_zero;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_x, add_y;
  logic        add_sub;
  logic [33:0] add_res;
  logic        no_borrow;
  logic [32:0] mul_sum;
  logic [31:0] hi_n, lo_n;
  logic [63:0] prod, prod_s;
  logic [31:0] fix_res;

  assign accept   = (state_q == StIdle) & req_i & ~kill_i;
  assign is_mul   = ~op_q[1];
  assign div_zero = op_q[1] & (b_q == 32'd0);
  assign neg_a    = mode_q[0] & a_q[31];
  assign neg_b    = mode_q[1] & b_q[31];
  // Two's complement negation leaves 0x80000000 unchanged, which is its correct magnitude.
  assign mag_a    = neg_a ? -a_q : a_q;
  assign mag_b    = neg_b ? -b_q : b_q;

  // Shared adder: acc + multiplicand for MUL, {rem, next dividend bit} - divisor for DIV.
  assign add_x     = is_mul ? {1'b0, hi_q} : {hi_q, lo_q[31]};
  assign add_y     = {1'b0, mag_b_q};
  assign add_sub   = ~is_mul;
  assign add_res   = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)} + {33'd0, add_sub};
  assign no_borrow = add_res[33];

  always_comb begin
    mul_sum = 33'd0;
    hi_n    = hi_q;
    lo_n    = lo_q;
    if (is_mul) begin
      mul_sum = lo_q[0] ? add_res[32:0] : {1'b0, hi_q};
      hi_n    = mul_sum[32:1];
      lo_n    = {mul_sum[0], lo_q[31:1]};
    end else begin
      hi_n = no_borrow ? add_res[31:0] : add_x[31:0];
      lo_n = {lo_q[30:0], no_borrow};
    end
  end

  assign prod   = {hi_q, lo_q};
  assign prod_s = (neg_a ^ neg_b) ? -prod : prod;

  always_comb begin
    fix_res = 32'd0;
    unique case (op_q)
      OpMull: fix_res = prod_s[31:0];
      OpMulh: fix_res = prod_s[63:32];
      OpDiv:  fix_res = div_zero ? 32'hFFFF_FFFF : ((neg_a ^ neg_b) ? -lo_q : lo_q);
      OpRem:  fix_res = div_zero ? a_q : (neg_a ? -hi_q : hi_q);
      default: fix_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (req_i) state_d = StAbs;
        // The zero-divisor shortcut still passes through FIX, which applies the override.
        StAbs:  state_d = (ZeroShortcut && div_zero) ? StFix : StIter;
        StIter: if (cnt_q == 5'd31) state_d = StFix;
        StFix:  state_d = StDone;
        StDone: if (ack_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= 2'd0;
      mode_q   <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      mag_b_q  <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_i;
        mode_q <= signed_mode_i;
        a_q    <= op_a_i;
        b_q    <= op_b_i;
      end
      if (state_q == StAbs) begin
        hi_q    <= 32'd0;
        lo_q    <= mag_a;
        mag_b_q <= mag_b;
        cnt_q   <= 5'd0;
      end
      if (state_q == StIter) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q + 5'd1;
      end
      if ((state_q == StFix) && !kill_i) begin
        result_q <= fix_res;
      end
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign valid_o  = (state_q == StDone);
  assign busy_o   = (state_q == StAbs) | (state_q == StIter) | (state_q == StFix);
  assign result_o = result_q;

endmodule

// File: tb/tb_brq_md_iter_ctrl.sv
// Bench for brq_md_iter_ctrl: directed and random ops on a shortcut and a full-latency
// instance, checked against a 64-bit arithmetic reference model.
module tb_brq_md_iter_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  op;
  logic [1:0]  mode;
  logic [31:0] op_a, op_b;
  logic        kill;
  logic        ack;

  logic        rdy1, vld1, bsy1;
  logic [31:0] res1;
  logic        rdy0, vld0, bsy0;
  logic [31:0] res0;

  int errors = 0;
  int checks = 0;

  brq_md_iter_ctrl #(.ZeroShortcut(1'b1)) u_dut_sc (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(rdy1), .op_i(op),
    .signed_mode_i(mode), .op_a_i(op_a), .op_b_i(op_b), .kill_i(kill),
    .valid_o(vld1), .ack_i(ack), .result_o(res1), .busy_o(bsy1)
  );

  brq_md_iter_ctrl #(.ZeroShortcut(1'b0)) u_dut_full (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(rdy0), .op_i(op),
    .signed_mode_i(mode), .op_a_i(op_a), .op_b_i(op_b), .kill_i(kill),
    .valid_o(vld0), .ack_i(ack), .result_o(res0), .busy_o(bsy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend operands per signedness to 64 bits and use plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [1:0] m,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    sa = m[0] ? {{32{a[31]}}, a} : {32'd0, a};
    sb = m[1] ? {{32{b[31]}}, b} : {32'd0, b};
    p  = sa * sb;
    case (o)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        q = sa % sb;
        return q[31:0];
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [1:0] m,
                       input logic [31:0] a, input logic [31:0] b);
    req = 1'b1; op = o; mode = m; op_a = a; op_b = b;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the DUT must ignore them.
    req = 1'b0; op = 2'($urandom); mode = 2'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r1, output logic [31:0] r0,
                        output int lat1, output int lat0, output bit hs_ok);
    int n;
    issue(o, m, a, b);
    lat1 = -1; lat0 = -1; n = 0; hs_ok = 1'b1; r1 = 32'hx; r0 = 32'hx;
    while ((lat1 < 0 || lat0 < 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (vld1 && lat1 < 0) begin lat1 = n; r1 = res1; end
      if (vld0 && lat0 < 0) begin lat0 = n; r0 = res0; end
      if (lat1 < 0 && (rdy1 || !bsy1)) hs_ok = 1'b0;
      if (lat0 < 0 && (rdy0 || !bsy0)) hs_ok = 1'b0;
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({rdy1, vld1, bsy1, res1} !== {3'b100, 32'd0} ||
        {rdy0, vld0, bsy0, res0} !== {3'b100, 32'd0}) begin
      errors++;
      $display("FAIL reset: got %b%b%b/%h %b%b%b/%h expected 100/00000000", rdy1, vld1, bsy1,
               res1, rdy0, vld0, bsy0, res0);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  ops[8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [1:0]  mds[8] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [31:0] as[8]  = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] bs[8]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2};
    logic [31:0] ex[8]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] r1, r0;
    int          l1, l0;
    bit          hs;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], mds[i], as[i], bs[i], r1, r0, l1, l0, hs);
      checks++;
      if (r1 !== ex[i] || r0 !== ex[i]) begin
        errors++;
        $display("FAIL directed_%0d result: got %h/%h expected %h", i, r1, r0, ex[i]);
      end
      checks++;
      if (l1 != 34 || l0 != 34 || !hs) begin
        errors++;
        $display("FAIL directed_%0d latency: got %0d/%0d hs=%0b expected 34/34 hs=1", i, l1,
                 l0, hs);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] r1, r0;
    int          l1, l0;
    bit          hs;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  o;
      logic [31:0] e;
      o = (i % 2 == 0) ? 2'd2 : 2'd3;
      e = (o == 2'd2) ? 32'hFFFF_FFFF : 32'h1234_5678;
      run_op(o, (i < 2) ? 2'b11 : 2'b00, 32'h1234_5678, 32'd0, r1, r0, l1, l0, hs);
      checks++;
      if (r1 !== e || r0 !== e) begin
        errors++;
        $display("FAIL divzero_%0d result: got %h/%h expected %h", i, r1, r0, e);
      end
      checks++;
      if (l1 != 2 || l0 != 34 || !hs) begin
        errors++;
        $display("FAIL divzero_%0d latency: got %0d/%0d expected 2/34", i, l1, l0);
      end
    end
  endtask

  task automatic test_kill;
    logic [31:0] r1, r0;
    int          l1, l0;
    bit          hs;
    issue(2'd2, 2'b11, 32'hDEAD_BEEF, 32'd3);
    repeat (11) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if ({rdy1, vld1, bsy1} !== 3'b100 || {rdy0, vld0, bsy0} !== 3'b100) begin
      errors++;
      $display("FAIL kill_iter: got %b%b%b/%b%b%b expected 100", rdy1, vld1, bsy1, rdy0, vld0,
               bsy0);
    end
    run_op(2'd2, 2'b00, 32'd100, 32'd7, r1, r0, l1, l0, hs);
    checks++;
    if (r1 !== 32'd14 || r0 !== 32'd14 || l1 != 34 || l0 != 34) begin
      errors++;
      $display("FAIL after_kill: got %h/%h lat %0d/%0d expected 0000000e lat 34", r1, r0, l1,
               l0);
    end
    // kill in IDLE blocks acceptance
    req = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; kill = 1'b0;
    checks++;
    if ({rdy1, bsy1, rdy0, bsy0} !== 4'b1010) begin
      errors++;
      $display("FAIL kill_idle: got %b%b%b%b expected 1010", rdy1, bsy1, rdy0, bsy0);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!(vld1 && vld0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(vld1 && vld0)) begin
      errors++;
      $display("FAIL %s timeout: got valid %b%b expected 11", name, vld1, vld0);
    end
  endtask

  task automatic test_ack_hold;
    bit stable = 1'b1;
    issue(2'd0, 2'b00, 32'd5, 32'd6);
    wait_valid("ack_hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!vld1 || !vld0 || res1 !== 32'd30 || res0 !== 32'd30) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL ack_hold: got %h/%h valid %b%b expected 0000001e valid 11", res1, res0,
               vld1, vld0);
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    checks++;
    if ({rdy1, vld1, rdy0, vld0} !== 4'b1010 || res1 !== 32'd30) begin
      errors++;
      $display("FAIL ack_pulse: got %b%b%b%b/%h expected 1010/0000001e", rdy1, vld1, rdy0,
               vld0, res1);
    end
    // ack and kill together in DONE
    issue(2'd0, 2'b00, 32'd9, 32'd9);
    wait_valid("ack_kill");
    ack = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; kill = 1'b0;
    checks++;
    if ({rdy1, vld1, bsy1, rdy0, vld0, bsy0} !== 6'b100100 || res1 !== 32'd81) begin
      errors++;
      $display("FAIL ack_kill: got %b%b%b%b%b%b/%h expected 100100/00000051", rdy1, vld1,
               bsy1, rdy0, vld0, bsy0, res1);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r1, r0;
    int          l1, l0;
    bit          hs;
    issue(2'd1, 2'b11, 32'hCAFE_F00D, 32'h1357_9BDF);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({rdy1, vld1, bsy1, res1} !== {3'b100, 32'd0} ||
        {rdy0, vld0, bsy0, res0} !== {3'b100, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid: got %b%b%b/%h expected 100/00000000", rdy1, vld1, bsy1, res1);
    end
    run_op(2'd3, 2'b00, 32'd100, 32'd7, r1, r0, l1, l0, hs);
    checks++;
    if (r1 !== 32'd2 || r0 !== 32'd2 || l1 != 34) begin
      errors++;
      $display("FAIL after_reset: got %h/%h lat %0d expected 00000002 lat 34", r1, r0, l1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r0, a, b, e;
    logic [1:0]  o, m;
    int          l1, l0, el1;
    bit          hs;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom); m = 2'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      e   = model(o, m, a, b);
      el1 = (o[1] && b == 32'd0) ? 2 : 34;
      run_op(o, m, a, b, r1, r0, l1, l0, hs);
      checks++;
      if (r1 !== e || r0 !== e || l1 != el1 || l0 != 34 || !hs) begin
        errors++;
        $display("FAIL rand_%0d op=%0d mode=%b a=%h b=%h: got %h/%h lat %0d/%0d expected %h lat %0d/34",
                 i, o, m, a, b, r1, r0, l1, l0, e, el1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = 2'd0; mode = 2'd0; op_a = 32'd0; op_b = 32'd0;
    kill = 1'b0; ack = 1'b0;
    test_reset();
    test_directed();
    test_div_zero();
    test_kill();
    test_ack_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
